cmd_frame_parser: RTL
=====================

# cmd_frame_parser

Command frame parser in the destination (system) clock domain, directly downstream of the data synchronizer. It consumes the synchronized byte bus and its one-cycle enable pulse, assembles multi-byte command frames, and issues single-cycle register-file write/read requests and ALU operation requests. Unknown opcodes and stalled frames are flagged and dropped, so the parser always returns to idle.

## Interface
- DATA_WIDTH, 8, width of the incoming byte bus, register data and ALU operands
- ADDR_WIDTH, 4, register-file address width, taken from the low bits of the address byte
- TIMEOUT_CYCLES, 1024, idle-gap limit inside a frame; used only when the timeout feature is compiled in

- CLK  in  1  system clock; one clock for the whole block
- RST  in  1  synchronous, active-high reset
- rx_data  in  DATA_WIDTH  synchronized byte (the synchronizer's sync_bus)
- rx_valid  in  1  one-cycle strobe meaning rx_data holds a new byte (the synchronizer's enable_pulse)
- rf_addr  out  ADDR_WIDTH  register-file address
- rf_wr_data  out  DATA_WIDTH  register-file write data
- rf_wr_en  out  1  one-cycle write request
- rf_rd_en  out  1  one-cycle read request
- alu_op_a  out  DATA_WIDTH  ALU operand A, held until the next operand frame
- alu_op_b  out  DATA_WIDTH  ALU operand B, held until the next operand frame
- alu_fun  out  4  ALU function code
- alu_en  out  1  one-cycle ALU start
- frame_busy  out  1  high while a frame is partially received
- cmd_err  out  1  one-cycle pulse on an unknown opcode
- timeout_err  out  1  one-cycle pulse when a frame is aborted by timeout

## Operation
- Opcodes, checked against rx_data in IDLE:
  - 0xAA: register write, frame is ADDR then DATA
  - 0xBB: register read, frame is ADDR
  - 0xCC: ALU operation with operands, frame is A, B, FUN
  - 0xDD: ALU operation without operands, frame is FUN
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN.
- A state advances only on a cycle with rx_valid = 1. With rx_valid = 0 the state holds.
- Transitions:
  - IDLE: 0xAA goes to WR_ADDR, 0xBB to RD_ADDR, 0xCC to ALU_A, 0xDD to ALU_FUN. Any other value pulses cmd_err and stays in IDLE.
  - WR_ADDR goes to WR_DATA, latching rf_addr from rx_data[ADDR_WIDTH-1:0].
  - WR_DATA goes to IDLE, latching rf_wr_data and pulsing rf_wr_en.
  - RD_ADDR goes to IDLE, latching rf_addr and pulsing rf_rd_en.
  - ALU_A goes to ALU_B, latching alu_op_a.
  - ALU_B goes to ALU_FUN, latching alu_op_b.
  - ALU_FUN goes to IDLE, latching alu_fun from rx_data[3:0] and pulsing alu_en.
- 0xDD reuses the alu_op_a and alu_op_b values from the last 0xCC frame, or reset values if none has occurred.
- Payload bytes are never interpreted as opcodes. A value of 0xAA sent as data is data.
- frame_busy is 1 in every state except IDLE.
- Address bits of a byte above ADDR_WIDTH-1 and function bits above bit 3 are ignored.

## Timing
- All outputs are registered. Every pulse (rf_wr_en, rf_rd_en, alu_en, cmd_err, timeout_err) is high for exactly one cycle, in the cycle after the accepting rx_valid edge.
- rf_addr, rf_wr_data and alu_fun are valid in the same cycle as their pulse and hold afterwards.
- Back-to-back bytes (rx_valid high on consecutive cycles) are all accepted with no loss. A new opcode may arrive in the cycle right after the final byte of a frame.
- Reset: state returns to IDLE, every output is 0 and the timeout counter is cleared. Reset mid-frame discards the partial frame, and no pulse is issued for it.

## Configuration
- Macro: CMD_FRAME_TIMEOUT_EN.
- When defined:
  - A counter runs in any non-IDLE state and clears on every rx_valid.
  - After TIMEOUT_CYCLES consecutive cycles without rx_valid, the state goes to IDLE and timeout_err pulses once. Latched outputs are not changed and no request pulse is issued.
  - If rx_valid coincides with the expiring cycle, the byte is accepted and the timeout does not fire.
- When undefined: no counter is built, timeout_err is tied to 0, and a partial frame waits indefinitely.

## Test plan
- Register write: 0xAA, 0x05, 0x3C, one byte per cycle, gives rf_wr_en for one cycle with rf_addr = 5 and rf_wr_data = 0x3C, then frame_busy = 0.
- Register read: 0xBB, 0xF7 with 3-cycle gaps gives rf_rd_en for one cycle with rf_addr = 7 (upper bits ignored). No rf_wr_en occurs.
- ALU operations:
  - 0xCC, 0x12, 0x34, 0x01 gives alu_en for one cycle with alu_op_a = 0x12, alu_op_b = 0x34 and alu_fun = 1.
  - A following 0xDD, 0x03 gives alu_en with alu_fun = 3 and operands still 0x12 / 0x34.
- Unknown opcode: 0x55 in IDLE pulses cmd_err once. A following 0xAA, 0x02, 0xAA writes data 0xAA to address 2.
- Abort cases:
  - RST asserted after 0xCC, 0x12 gives all outputs 0 and no alu_en.
  - With CMD_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES = 16, sending 0xAA then silence pulses timeout_err once after 16 idle cycles. A subsequent 0xBB, 0x01 is parsed normally.

Source files
------------

// File: rtl/cmd_frame_parser_if.sv
// Bundles the synchronized byte stream into the parser and the register-file /
// ALU request outputs it produces; the parser uses the slave modport.
interface cmd_frame_parser_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic                  rf_wr_en;
  logic                  rf_rd_en;
  logic [DATA_WIDTH-1:0] alu_op_a;
  logic [DATA_WIDTH-1:0] alu_op_b;
  logic [3:0]            alu_fun;
  logic                  alu_en;
  logic                  frame_busy;
  logic                  cmd_err;
  logic                  timeout_err;

  modport master (
    output rx_data, rx_valid,
    input  rf_addr, rf_wr_data, rf_wr_en, rf_rd_en,
    input  alu_op_a, alu_op_b, alu_fun, alu_en,
    input  frame_busy, cmd_err, timeout_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output rf_addr, rf_wr_data, rf_wr_en, rf_rd_en,
    output alu_op_a, alu_op_b, alu_fun, alu_en,
    output frame_busy, cmd_err, timeout_err
  );
endinterface

// File: rtl/cmd_frame_parser.sv
// Command frame parser: turns synchronized bytes into register-file and ALU requests.
// Define CMD_FRAME_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYCLES cycles.
module cmd_frame_parser #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              CLK,
  input logic              RST,
  cmd_frame_parser_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] ALU_A   = 3'd4;
  localparam logic [2:0] ALU_B   = 3'd5;
  localparam logic [2:0] ALU_FUN = 3'd6;

  localparam logic [DATA_WIDTH-1:0] OP_WRITE   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_READ    = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU     = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_FUN = DATA_WIDTH'(8'hDD);

  logic [2:0] state;

  assign bus.frame_busy = (state != IDLE);

`ifdef CMD_FRAME_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] idle_cnt;
  logic          expire;

  // Expiry is only possible on a cycle with no byte, so an arriving byte always wins.
  assign expire = (state != IDLE) && !bus.rx_valid && (idle_cnt == LAST_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      idle_cnt        <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.timeout_err <= expire;
      if (state == IDLE || bus.rx_valid || expire)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  logic expire;

  assign expire          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      bus.rf_addr    <= '0;
      bus.rf_wr_data <= '0;
      bus.rf_wr_en   <= 1'b0;
      bus.rf_rd_en   <= 1'b0;
      bus.alu_op_a   <= '0;
      bus.alu_op_b   <= '0;
      bus.alu_fun    <= '0;
      bus.alu_en     <= 1'b0;
      bus.cmd_err    <= 1'b0;
    end else begin
      bus.rf_wr_en <= 1'b0;
      bus.rf_rd_en <= 1'b0;
      bus.alu_en   <= 1'b0;
      bus.cmd_err  <= 1'b0;
      if (bus.rx_valid) begin
        case (state)
          IDLE: begin
            if (bus.rx_data == OP_WRITE)        state <= WR_ADDR;
            else if (bus.rx_data == OP_READ)    state <= RD_ADDR;
            else if (bus.rx_data == OP_ALU)     state <= ALU_A;
            else if (bus.rx_data == OP_ALU_FUN) state <= ALU_FUN;
            else                                bus.cmd_err <= 1'b1;
          end
          WR_ADDR: begin
            bus.rf_addr <= bus.rx_data[ADDR_WIDTH-1:0];
            state       <= WR_DATA;
          end
          WR_DATA: begin
            bus.rf_wr_data <= bus.rx_data;
            bus.rf_wr_en   <= 1'b1;
            state          <= IDLE;
          end
          RD_ADDR: begin
            bus.rf_addr  <= bus.rx_data[ADDR_WIDTH-1:0];
            bus.rf_rd_en <= 1'b1;
            state        <= IDLE;
          end
          ALU_A: begin
            bus.alu_op_a <= bus.rx_data;
            state        <= ALU_B;
          end
          ALU_B: begin
            bus.alu_op_b <= bus.rx_data;
            state        <= ALU_FUN;
          end
          ALU_FUN: begin
            bus.alu_fun <= bus.rx_data[3:0];
            bus.alu_en  <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (expire) begin
        state <= IDLE;
      end
    end
  end

endmodule
